// File: rtl/lane_scatter.sv
// lane_scatter: steers a single tagged write stream into LANES one-entry
// holding registers, one per generated lane slot. Each lane drains on its own
// valid/ready pair. A flush request stops intake until every lane is empty.
//
// Build option: define LANE_SCATTER_REDIRECT_EN to steer out-of-range writes
// to DEFAULT_LANE. Without it, out-of-range writes are accepted and dropped.
// In both builds an out-of-range write raises the sticky err_bad_lane flag.

module lane_scatter #(
    parameter int LANES        = 4,
    parameter int DW           = 8,
    parameter int IW           = $clog2(LANES) + 1,
    parameter int DEFAULT_LANE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IW-1:0]         in_lane,
    input  logic [DW-1:0]         in_data,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [LANES-1:0]      lane_valid,
    output logic [LANES*DW-1:0]   lane_data,
    input  logic [LANES-1:0]      lane_ready,
    output logic                  err_bad_lane,
    output logic [15:0]           wr_count
);

    localparam logic [0:0]    ST_RUN     = 1'b0;
    localparam logic [0:0]    ST_DRAIN   = 1'b1;
    localparam logic [IW-1:0] LANE_LIMIT = IW'(LANES);

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic             oob_s;
    logic [LANES-1:0] hit_s;
    logic             lane_open_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [LANES-1:0] load_s;
    logic             flush_done_s;
    logic             err_bad_lane_r;
    logic [15:0]      wr_count_r;

    // Decode the target lane and work out whether this write can be taken now.
    always_comb begin
        oob_s       = (in_lane >= LANE_LIMIT);
        hit_s       = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
`ifdef LANE_SCATTER_REDIRECT_EN
            hit_s[i] = (in_lane == IW'(i)) || (oob_s && (i == DEFAULT_LANE));
`else
            hit_s[i] = (in_lane == IW'(i));
`endif
        end
        // A lane can take a write when empty or when it empties on this edge.
        lane_open_s = |(hit_s & (~lane_valid | lane_ready));
        in_ready_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
`ifdef LANE_SCATTER_REDIRECT_EN
                in_ready_s = lane_open_s;
`else
                if (oob_s) begin
                    in_ready_s = 1'b1;
                end else begin
                    in_ready_s = lane_open_s;
                end
`endif
            end
            ST_DRAIN: in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase
        accept_s = in_valid && in_ready_s;
        load_s   = hit_s & {LANES{accept_s}};
    end

    // Next-state logic: RUN waits for flush, DRAIN waits for all lanes empty.
    always_comb begin
        state_nxt_s  = state_r;
        flush_done_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A reset in this cycle abandons the flush, so no completion pulse.
                if ((lane_valid == {LANES{1'b0}}) && !rst) begin
                    state_nxt_s  = ST_RUN;
                    flush_done_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s  = ST_RUN;
                flush_done_s = 1'b0;
            end
        endcase
    end

    // Flush state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sticky error flag for any accepted write with an out-of-range index.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_bad_lane_r <= 1'b0;
        end else if (accept_s && oob_s) begin
            err_bad_lane_r <= 1'b1;
        end else begin
            err_bad_lane_r <= err_bad_lane_r;
        end
    end

    // Count writes that actually land in a lane; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_r <= 16'd0;
        end else if (|load_s) begin
            wr_count_r <= wr_count_r + 16'd1;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic          vld_r;
        logic [DW-1:0] dat_r;

        // One-entry holding register; a load wins over a drain in the same cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= 1'b0;
                dat_r <= {DW{1'b0}};
            end else if (load_s[g]) begin
                vld_r <= 1'b1;
                dat_r <= in_data;
            end else if (vld_r && lane_ready[g]) begin
                vld_r <= 1'b0;
                dat_r <= dat_r;
            end else begin
                vld_r <= vld_r;
                dat_r <= dat_r;
            end
        end

        assign lane_valid[g]          = vld_r;
        assign lane_data[g*DW +: DW]  = dat_r;
    end

    assign in_ready     = in_ready_s;
    assign flush_done   = flush_done_s;
    assign err_bad_lane = err_bad_lane_r;
    assign wr_count     = wr_count_r;

endmodule

// File: tb/tb_lane_scatter.sv
// Directed bench for lane_scatter (default build: redirect disabled).
module tb_lane_scatter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_lane;
    logic [7:0]  in_data;
    logic        flush;
    logic        flush_done;
    logic [3:0]  lane_valid;
    logic [31:0] lane_data;
    logic [3:0]  lane_ready;
    logic        err_bad_lane;
    logic [15:0] wr_count;

    int total;
    int bad;

    lane_scatter #(.LANES(4), .DW(8), .IW(3), .DEFAULT_LANE(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane(in_lane), .in_data(in_data),
        .flush(flush), .flush_done(flush_done),
        .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready),
        .err_bad_lane(err_bad_lane), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  lane;
        logic [7:0]  data;
        logic        flush;
        logic [3:0]  ready;
        logic        exp_ready;
        logic        exp_fd;
        logic [3:0]  exp_lv;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //           vld lane  data   fl ready    rdy fd  lv       data           err cnt
        vecs[0]  = '{1'b1, 3'd2, 8'hA5, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 32'h00A50000, 1'b0, 16'd1};
        vecs[1]  = '{1'b1, 3'd2, 8'h77, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 32'h00A50000, 1'b0, 16'd1};
        vecs[2]  = '{1'b1, 3'd2, 8'h3C, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 32'h003C0000, 1'b0, 16'd2};
        vecs[3]  = '{1'b1, 3'd0, 8'h12, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0101, 32'h003C0012, 1'b0, 16'd3};
        vecs[4]  = '{1'b1, 3'd3, 8'h34, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1101, 32'h343C0012, 1'b0, 16'd4};
        vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b1001, 32'h343C0012, 1'b0, 16'd4};
        vecs[6]  = '{1'b1, 3'd1, 8'h56, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b1011, 32'h343C5612, 1'b0, 16'd5};
        vecs[7]  = '{1'b1, 3'd1, 8'h99, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1011, 32'h343C5612, 1'b0, 16'd5};
        vecs[8]  = '{1'b0, 3'd1, 8'h99, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1011, 32'h343C5612, 1'b0, 16'd5};
        vecs[9]  = '{1'b0, 3'd1, 8'h99, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 32'h343C5612, 1'b0, 16'd5};
        vecs[10] = '{1'b1, 3'd1, 8'h99, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 32'h343C5612, 1'b0, 16'd5};
        vecs[11] = '{1'b1, 3'd1, 8'h99, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 32'h343C9912, 1'b0, 16'd6};
        vecs[12] = '{1'b1, 3'd5, 8'h11, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 32'h343C9912, 1'b1, 16'd6};
        vecs[13] = '{1'b1, 3'd4, 8'h22, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 32'h343C9912, 1'b1, 16'd6};
        vecs[14] = '{1'b0, 3'd0, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h343C9912, 1'b1, 16'd6};
        vecs[15] = '{1'b0, 3'd0, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 32'h343C9912, 1'b1, 16'd6};
        vecs[16] = '{1'b1, 3'd0, 8'h01, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 32'h343C9901, 1'b1, 16'd7};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_lane = 3'd0; in_data = 8'h00;
        flush = 1'b0; lane_ready = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lane_valid", 64'(lane_valid), 64'h0);
        chk("rst_lane_data", 64'(lane_data), 64'h0);
        chk("rst_err", 64'(err_bad_lane), 64'h0);
        chk("rst_count", 64'(wr_count), 64'h0);
        chk("rst_flush_done", 64'(flush_done), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = vecs[i].valid; in_lane = vecs[i].lane; in_data = vecs[i].data;
            flush = vecs[i].flush; lane_ready = vecs[i].ready;
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
            chk($sformatf("v%0d_flush_done", i), 64'(flush_done), 64'(vecs[i].exp_fd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_lane_valid", i), 64'(lane_valid), 64'(vecs[i].exp_lv));
            chk($sformatf("v%0d_lane_data", i), 64'(lane_data), 64'(vecs[i].exp_data));
            chk($sformatf("v%0d_err", i), 64'(err_bad_lane), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_count", i), 64'(wr_count), 64'(vecs[i].exp_cnt));
        end

        // Counter wrap: stream back-to-back writes into lane 0 with it always ready
        @(negedge clk);
        in_valid = 1'b1; in_lane = 3'd0; in_data = 8'h5A; flush = 1'b0; lane_ready = 4'b0001;
        for (int n = 0; n < 65535 - 7; n++) begin
            @(posedge clk);
        end
        #1;
        chk("wrap_count_ffff", 64'(wr_count), 64'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap_count_zero", 64'(wr_count), 64'h0);

        // Reset while draining with lanes 0 and 3 full
        @(negedge clk);
        in_valid = 1'b1; in_lane = 3'd3; in_data = 8'hAB; lane_ready = 4'b0000;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk("pre_rst_lane_valid", 64'(lane_valid), 64'b1001);
        @(negedge clk);
        flush = 1'b0; rst = 1'b1;
        #1;
        chk("drain_in_ready", 64'(in_ready), 64'h0);
        chk("rst_cycle_flush_done", 64'(flush_done), 64'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_lane_valid", 64'(lane_valid), 64'h0);
        chk("mid_rst_lane_data", 64'(lane_data), 64'h0);
        chk("mid_rst_err", 64'(err_bad_lane), 64'h0);
        chk("mid_rst_count", 64'(wr_count), 64'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_lane = 3'd1; in_data = 8'h42;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'h1);
        chk("post_rst_flush_done", 64'(flush_done), 64'h0);
        @(posedge clk);
        #1;
        chk("post_rst_lane_valid", 64'(lane_valid), 64'b0010);
        chk("post_rst_lane_data", 64'(lane_data), 64'h00004200);
        chk("post_rst_count", 64'(wr_count), 64'h1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post_rst_no_done", 64'(flush_done), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_scatter.md
# lane_scatter

Write-side counterpart to a generate-loop of per-lane instances. It takes one stream of writes, each tagged with a lane index, and steers each write into a one-entry holding register inside a generated lane slot. Each lane drains independently via its own valid/ready pair. It sits between a single producer and `LANES` generated consumers, the mirror of a block that reads one lane selected by an index. A flush request stops intake until every lane has drained.

## Interface
Parameters:
- `LANES`, 4, number of generated lane slots (≥2).
- `DW`, 8, data width per write.
- `IW`, `$clog2(LANES)+1`, lane-index width; one spare bit so out-of-range indices can be presented.
- `DEFAULT_LANE`, 2, redirect target when the redirect feature is compiled in; must be < `LANES`.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: producer write request.
- `in_ready` out 1: write accepted this cycle when high together with `in_valid`.
- `in_lane` in `IW`: target lane index.
- `in_data` in `DW`: write payload.
- `flush` in 1: one-cycle pulse that requests a drain.
- `flush_done` out 1: one-cycle pulse when the drain completes.
- `lane_valid` out `LANES`: per-lane holding register occupied.
- `lane_data` out `LANES*DW`: lane i occupies bits `[i*DW +: DW]`.
- `lane_ready` in `LANES`: per-lane consumer ready.
- `err_bad_lane` out 1: sticky flag for an out-of-range index.
- `wr_count` out 16: count of writes accepted into a lane.

## Operation
- Per lane (generate loop): one register plus a valid bit.
  - Load when the lane is selected and the write is accepted.
  - Clear when `lane_valid[i] && lane_ready[i]` and there is no load in the same cycle.
  - Load and drain in the same cycle: the new data replaces the old and valid stays 1 (pass-through, no bubble).
- State machine, states RUN and DRAIN:
  - RUN: `in_ready = (in_lane < LANES) ? (!lane_valid[in_lane] || lane_ready[in_lane]) : 1`.
  - RUN→DRAIN on `flush`. A write presented in the same cycle as `flush` is still accepted.
  - DRAIN: `in_ready = 0`.
  - DRAIN→RUN in the first cycle with `lane_valid == 0`; `flush_done` pulses in that cycle.
  - `flush` while already in DRAIN is ignored.
- Out-of-range index (`in_lane >= LANES`) without the redirect feature:
  - The write is accepted (`in_ready=1`) and discarded.
  - `err_bad_lane` is set and stays 1 until `rst`.
  - `wr_count` is not incremented.
- `wr_count` increments by 1 per write that loads a lane. It wraps from 0xFFFF to 0.
- Reset values: `lane_valid=0`, `lane_data=0`, `err_bad_lane=0`, `wr_count=0`, state RUN, `flush_done=0`.

## Timing
- Latency: a write accepted in cycle N shows on `lane_valid`/`lane_data` in cycle N+1.
- `in_ready` is combinational from `in_lane`, `lane_valid`, `lane_ready` and state. It never depends on `in_valid`.
- Producer rule: `in_lane`, `in_data` and `in_valid` must stay stable while `in_valid && !in_ready`.
- Lane drain: data leaves on the `clk` edge where `lane_valid[i] && lane_ready[i]`.
- `flush_done` goes high at the earliest one cycle after `flush`, even if all lanes are already empty.
- `rst` asserted mid-operation:
  - All held data is lost.
  - A pending flush is abandoned and no `flush_done` is issued.
  - Outputs take their reset values on the next edge.

## Configuration
- `LANE_SCATTER_REDIRECT_EN` defined: out-of-range writes are steered to `DEFAULT_LANE`.
  - `in_ready` follows that lane's availability.
  - `wr_count` increments.
  - `err_bad_lane` is still set (sticky).
- `LANE_SCATTER_REDIRECT_EN` undefined: out-of-range writes are dropped as described in Operation.

## Test plan
- Reset, then write lane 2 with 0xA5 while `lane_ready=0` → next cycle `lane_valid=4'b0100` and `lane_data[23:16]=0xA5`; a second write to lane 2 sees `in_ready=0`.
- Lane 2 full with `lane_ready[2]=1`, write 0x3C to lane 2 → accepted; next cycle lane 2 holds 0x3C and `lane_valid[2]=1`; `wr_count=2`.
- Lanes 0 and 3 full, `lane_ready=0`, pulse `flush` → `in_ready=0`; raise `lane_ready` two cycles later → `flush_done` pulses once, state returns to RUN, `in_ready` recovers.
- Write `in_lane=5` with data 0x11 (macro off) → accepted, no lane loads, `err_bad_lane=1`, `wr_count` unchanged. With the macro on → lane 2 holds 0x11 and `wr_count` increments.
- Preload `wr_count` to 0xFFFF via 65535 writes, then one more write → `wr_count=0`.
- Assert `rst` during DRAIN with lanes full → next cycle all outputs are 0, no `flush_done` pulse, and intake resumes.
